// File: rtl/braille_stream_decoder.sv
// Serial 6-dot Braille cell decoder with capital/number sign handling.
// Decoded characters go into a small output FIFO with a valid/ready handshake.
module braille_stream_decoder #(
    parameter int FIFO_DEPTH      = 4,
    parameter bit SPACE_EXITS_NUM = 1'b1
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       I,
    input  logic       IV,
    output logic [7:0] Y,
    output logic       INV,
    output logic       YV,
    input  logic       YR,
    output logic       OVF
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0] INV_ENTRY = {1'b1, 8'h3F};
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    logic [2:0]    r_cnt;
    logic [4:0]    r_sh;
    logic          r_num;
    logic          r_cap;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          r_ovf;

    logic          w_done;
    logic [5:0]    w_code;
    logic          w_is_let;
    logic [4:0]    w_idx;
    logic          w_push;
    logic [8:0]    w_pdata;
    logic          w_num_nxt;
    logic          w_cap_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_done = IV && (r_cnt == 3'd5);
    assign w_code = {I, r_sh};

    // Cell code bit k-1 is dot k; returns letter index 0 (a) .. 25 (z).
    always_comb begin
        w_is_let = 1'b1;
        w_idx    = 5'd0;
        case (w_code)
            6'h01: w_idx = 5'd0;
            6'h03: w_idx = 5'd1;
            6'h09: w_idx = 5'd2;
            6'h19: w_idx = 5'd3;
            6'h11: w_idx = 5'd4;
            6'h0B: w_idx = 5'd5;
            6'h1B: w_idx = 5'd6;
            6'h13: w_idx = 5'd7;
            6'h0A: w_idx = 5'd8;
            6'h1A: w_idx = 5'd9;
            6'h05: w_idx = 5'd10;
            6'h07: w_idx = 5'd11;
            6'h0D: w_idx = 5'd12;
            6'h1D: w_idx = 5'd13;
            6'h15: w_idx = 5'd14;
            6'h0F: w_idx = 5'd15;
            6'h1F: w_idx = 5'd16;
            6'h17: w_idx = 5'd17;
            6'h0E: w_idx = 5'd18;
            6'h1E: w_idx = 5'd19;
            6'h25: w_idx = 5'd20;
            6'h27: w_idx = 5'd21;
            6'h3A: w_idx = 5'd22;
            6'h2D: w_idx = 5'd23;
            6'h3D: w_idx = 5'd24;
            6'h35: w_idx = 5'd25;
            default: w_is_let = 1'b0;
        endcase
    end

    always_comb begin
        w_push    = 1'b0;
        w_pdata   = 9'd0;
        w_num_nxt = r_num;
        w_cap_nxt = r_cap;
        if (w_done) begin
            case (w_code)
                6'h20: begin
                    w_cap_nxt = 1'b1;
                    w_num_nxt = 1'b0;
                end
                6'h3C: begin
                    w_num_nxt = 1'b1;
                    w_cap_nxt = 1'b0;
                end
                6'h30: w_num_nxt = 1'b0;
                6'h00: begin
                    w_push    = 1'b1;
                    w_pdata   = r_cap ? INV_ENTRY : {1'b0, 8'h20};
                    w_cap_nxt = 1'b0;
                    if (SPACE_EXITS_NUM) w_num_nxt = 1'b0;
                end
                default: begin
                    w_push = 1'b1;
                    if (!w_is_let) begin
                        w_pdata = INV_ENTRY;
                    end else if (r_num && (w_idx < 5'd10)) begin
                        w_cap_nxt = 1'b0;
                        if (r_cap)
                            w_pdata = INV_ENTRY;
                        else if (w_idx == 5'd9)
                            w_pdata = {1'b0, 8'h30};
                        else
                            w_pdata = {1'b0, 8'h31 + {3'b000, w_idx}};
                    end else begin
                        w_cap_nxt = 1'b0;
                        w_num_nxt = 1'b0;
                        w_pdata   = {1'b0, (r_cap ? 8'h41 : 8'h61) + {3'b000, w_idx}};
                    end
                end
            endcase
        end
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_pop   = YR && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_cnt   <= 3'd0;
            r_sh    <= 5'd0;
            r_num   <= 1'b0;
            r_cap   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (IV) begin
                if (w_done) begin
                    r_cnt <= 3'd0;
                    r_sh  <= 5'd0;
                end else begin
                    r_cnt       <= r_cnt + 3'd1;
                    r_sh[r_cnt] <= I;
                end
            end
            r_num <= w_num_nxt;
            r_cap <= w_cap_nxt;
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wp] <= w_pdata;
    end

    assign YV  = !w_empty;
    assign Y   = w_empty ? 8'h00 : r_mem[r_rp][7:0];
    assign INV = w_empty ? 1'b0  : r_mem[r_rp][8];
    assign OVF = r_ovf;

endmodule

// File: tb/tb_braille_stream_decoder.sv
// Directed bench for braille_stream_decoder: expected entries are queued as
// cells are sent and compared as the consumer pops them.
module tb_braille_stream_decoder;

    logic       CLK = 1'b0;
    logic       R   = 1'b0;
    logic       I   = 1'b0;
    logic       IV  = 1'b0;
    logic [7:0] Y;
    logic       INV;
    logic       YV;
    logic       YR  = 1'b0;
    logic       OVF;

    int checks    = 0;
    int failures  = 0;
    int pop_count = 0;
    logic [8:0] exp_q [$];

    localparam logic [5:0] C_CAP = 6'h20, C_NUM = 6'h3C, C_LET = 6'h30, C_SP = 6'h00;
    localparam logic [5:0] C_A = 6'h01, C_B = 6'h03, C_I = 6'h0A, C_K = 6'h05;
    localparam logic [5:0] C_N = 6'h1D, C_Z = 6'h35, C_D3 = 6'h04;

    braille_stream_decoder #(.FIFO_DEPTH(4), .SPACE_EXITS_NUM(1'b1)) dut (
        .CLK(CLK), .R(R), .I(I), .IV(IV),
        .Y(Y), .INV(INV), .YV(YV), .YR(YR), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Consumer side: pop-compare against the queue, and check the head holds under backpressure.
    logic       prev_hold = 1'b0;
    logic [8:0] prev_val  = 9'd0;
    always @(negedge CLK) begin
        if (R === 1'b1) begin
            if (prev_hold && YV === 1'b1)
                chk("hold_stable", {23'd0, INV, Y}, {23'd0, prev_val});
            if (YV === 1'b1 && YR === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", {23'd0, INV, Y}, 32'h1FF_FFFF);
                end else begin
                    chk("entry", {23'd0, INV, Y}, {23'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                pop_count++;
            end
            prev_hold = (YV === 1'b1) && (YR === 1'b0);
            prev_val  = {INV, Y};
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Sends dot1 first; gap inserts IV=0 cycles after each bit.
    task automatic send_cell(input logic [5:0] d, input int gap);
        for (int k = 0; k < 6; k++) begin
            I  = d[k];
            IV = 1'b1;
            @(posedge CLK);
            #1;
            IV = 1'b0;
            I  = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_Y", Y, 0);
        chk("rst_INV", INV, 0);
        chk("rst_YV", YV, 0);
        chk("rst_OVF", OVF, 0);
        @(negedge CLK);
        R  = 1'b1;
        YR = 1'b1;
        @(posedge CLK);
        #1;

        // single 'i', latency and pop
        exp_q.push_back({1'b0, 8'h69});
        send_cell(C_I, 0);
        chk("lat_YV", YV, 1);
        chk("lat_Y", Y, 8'h69);
        chk("lat_INV", INV, 0);
        @(posedge CLK);
        #1;
        chk("after_pop_YV", YV, 0);
        chk("after_pop_Y", Y, 0);

        // number mode, space exits it
        send_cell(C_NUM, 0);
        exp_q.push_back({1'b0, 8'h39}); send_cell(C_I, 0);
        exp_q.push_back({1'b0, 8'h31}); send_cell(C_A, 0);
        exp_q.push_back({1'b0, 8'h20}); send_cell(C_SP, 0);
        exp_q.push_back({1'b0, 8'h61}); send_cell(C_A, 0);
        // k-z in number mode emits the letter and leaves number mode
        send_cell(C_NUM, 0);
        exp_q.push_back({1'b0, 8'h6B}); send_cell(C_K, 0);
        exp_q.push_back({1'b0, 8'h61}); send_cell(C_A, 0);
        // letter sign clears number mode; repeated number sign is a no-op
        send_cell(C_NUM, 0);
        send_cell(C_NUM, 0);
        exp_q.push_back({1'b0, 8'h30}); send_cell(C_I ^ 6'h10, 0);
        send_cell(C_LET, 0);
        exp_q.push_back({1'b0, 8'h62}); send_cell(C_B, 0);
        drain();

        // capitals
        send_cell(C_CAP, 0);
        exp_q.push_back({1'b0, 8'h41}); send_cell(C_A, 0);
        send_cell(C_CAP, 0);
        exp_q.push_back({1'b1, 8'h3F}); send_cell(C_SP, 0);
        send_cell(C_CAP, 0);
        send_cell(C_CAP, 0);
        exp_q.push_back({1'b0, 8'h5A}); send_cell(C_Z, 0);
        exp_q.push_back({1'b0, 8'h7A}); send_cell(C_Z, 0);
        // capital sign cancels number mode
        send_cell(C_NUM, 0);
        send_cell(C_CAP, 0);
        exp_q.push_back({1'b0, 8'h41}); send_cell(C_A, 0);
        // plain letters and an undefined cell
        exp_q.push_back({1'b0, 8'h6E}); send_cell(C_N, 0);
        exp_q.push_back({1'b1, 8'h3F}); send_cell(C_D3, 0);
        exp_q.push_back({1'b0, 8'h61}); send_cell(C_A, 0);
        drain();

        // backpressure and overflow
        YR = 1'b0;
        pop_count = 0;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back({1'b0, 8'h61});
            send_cell(C_A, 0);
        end
        chk("ovf_before", OVF, 0);
        send_cell(C_A, 0);
        chk("ovf_set", OVF, 1);
        chk("full_YV", YV, 1);
        chk("full_head", {INV, Y}, {1'b0, 8'h61});
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        chk("held_head", {INV, Y}, {1'b0, 8'h61});
        YR = 1'b1;
        drain();
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("pop_count", pop_count, 4);
        chk("empty_after", YV, 0);
        chk("ovf_sticky", OVF, 1);

        // gapped strobe decodes like a contiguous stream
        exp_q.push_back({1'b0, 8'h6E}); send_cell(C_N, 3);
        send_cell(C_NUM, 2);
        exp_q.push_back({1'b0, 8'h39}); send_cell(C_I, 1);
        send_cell(C_SP ^ 6'h00, 0);
        exp_q.push_back({1'b0, 8'h20});
        drain();

        // reset mid-cell discards partial bits
        I = 1'b1; IV = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        IV = 1'b0; I = 1'b0;
        #2 R = 1'b0;
        #3;
        chk("midrst_YV", YV, 0);
        chk("midrst_OVF", OVF, 0);
        R = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back({1'b0, 8'h62}); send_cell(C_B, 0);
        drain();
        chk("final_OVF", OVF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
